irq_ctrl: RTL and testbench

//   Interrupt controller feeding the CPU's single interrupt line (inter).

---
 rtl/irq_ctrl.sv | 130 +++++++++++++
 tb/tb_irq_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-capturing, maskable, fixed-priority interrupt controller with CPU handshake (IRQ_NEST_EN enables preemption)
module irq_ctrl #(
  parameter int               NSRC       = 4,
  parameter int               VEC_W      = 10,
  parameter logic [VEC_W-1:0] VEC_BASE   = 10'h3C0,
  parameter int               VEC_STRIDE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NSRC-1:0]  src,
  input  logic             mask_we,
  input  logic [NSRC-1:0]  mask_wdata,
  input  logic             ack,
  input  logic             reti,
  output logic             inter,
  output logic [VEC_W-1:0] vec,
  output logic [NSRC-1:0]  pend,
  output logic [NSRC-1:0]  in_svc,
  output logic             busy
);
  localparam int SW = $clog2(NSRC);
  localparam logic [NSRC-1:0] ONE = 1;
  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;
  state_t           r_state, w_state_n;
  logic [NSRC-1:0]  r_src_q, r_pend, r_mask, r_in_svc, w_in_svc_n, w_pm, w_clr;
  logic [SW-1:0]    r_sel_q, w_sel_q_n, w_sel, w_cur;
  logic [VEC_W-1:0] r_vec, w_vec_n, w_vec;
  logic             r_inter, w_inter_n, w_preempt, w_stk_empty;
  assign w_pm   = r_pend & r_mask;
  assign w_vec  = VEC_BASE + VEC_W'(VEC_STRIDE) * VEC_W'(w_sel);
  assign inter  = r_inter;
  assign vec    = r_vec;
  assign pend   = r_pend;
  assign in_svc = r_in_svc;
  assign busy   = r_state != IDLE;
  // Priority encoder: lowest-index enabled pending source wins
  always_comb begin
    w_sel = '0;
    for (int i = NSRC - 1; i >= 0; i--) if (w_pm[i]) w_sel = SW'(i);
  end
`ifdef IRQ_NEST_EN
  logic [SW-1:0] r_cur;
  logic [SW-1:0] r_stk [NSRC];
  logic [SW:0]   r_sp, w_sp_m1;
  logic          r_cur_v;
  assign w_sp_m1     = r_sp - 1'b1;
  assign w_cur       = r_cur;
  assign w_stk_empty = r_sp == '0;
  assign w_preempt   = |w_pm && w_sel < r_cur;
  // Nesting stack: ack pushes the interrupted id, reti resumes the popped one
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sp    <= '0;
      r_cur   <= '0;
      r_cur_v <= 1'b0;
    end else if (r_state == REQ && ack) begin
      if (r_cur_v) begin
        r_stk[r_sp[SW-1:0]] <= r_cur;
        r_sp <= r_sp + 1'b1;
      end
      r_cur   <= r_sel_q;
      r_cur_v <= 1'b1;
    end else if (r_state == SERV && reti) begin
      if (!w_stk_empty) begin
        r_cur <= r_stk[w_sp_m1[SW-1:0]];
        r_sp  <= w_sp_m1;
      end else r_cur_v <= 1'b0;
    end
  end
`else
  assign w_cur       = r_sel_q;
  assign w_stk_empty = 1'b1;
  assign w_preempt   = 1'b0;
`endif
  // Handshake FSM next-state; sel_q/vec only reload when a request is launched
  always_comb begin
    w_state_n  = r_state;
    w_sel_q_n  = r_sel_q;
    w_vec_n    = r_vec;
    w_inter_n  = r_inter;
    w_in_svc_n = r_in_svc;
    w_clr      = '0;
    case (r_state)
      IDLE: if (|w_pm) begin
        w_state_n = REQ;
        w_sel_q_n = w_sel;
        w_vec_n   = w_vec;
        w_inter_n = 1'b1;
      end
      REQ: if (ack) begin
        w_clr      = ONE << r_sel_q;
        w_in_svc_n = r_in_svc | (ONE << r_sel_q);
        w_inter_n  = 1'b0;
        w_state_n  = SERV;
      end
      SERV: if (reti) begin
        w_in_svc_n = r_in_svc & ~(ONE << w_cur);
        w_state_n  = w_stk_empty ? IDLE : SERV;
      end else if (w_preempt) begin
        w_state_n = REQ;
        w_sel_q_n = w_sel;
        w_vec_n   = w_vec;
        w_inter_n = 1'b1;
      end
      default: w_state_n = IDLE;
    endcase
  end
  // State, edge capture (new edge beats ack-clear), mask and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_src_q  <= '0;
      r_pend   <= '0;
      r_mask   <= '0;
      r_in_svc <= '0;
      r_sel_q  <= '0;
      r_vec    <= '0;
      r_inter  <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_src_q  <= src;
      r_pend   <= (r_pend & ~w_clr) | (src & ~r_src_q);
      r_mask   <= mask_we ? mask_wdata : r_mask;
      r_in_svc <= w_in_svc_n;
      r_sel_q  <= w_sel_q_n;
      r_vec    <= w_vec_n;
      r_inter  <= w_inter_n;
    end
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed-vector bench for irq_ctrl (nesting expectations follow IRQ_NEST_EN)
module tb_irq_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] src = '0;
  logic       mask_we = 1'b0;
  logic [3:0] mask_wdata = '0;
  logic       ack = 1'b0;
  logic       reti = 1'b0;
  logic       inter;
  logic [9:0] vec;
  logic [3:0] pend;
  logic [3:0] in_svc;
  logic       busy;
  int nv = 0;
  int ne = 0;
  irq_ctrl dut (
    .clk(clk), .reset(reset), .src(src), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .ack(ack), .reti(reti), .inter(inter), .vec(vec), .pend(pend), .in_svc(in_svc), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    reset = 1'b1; src = '0; mask_we = 1'b0; mask_wdata = '0; ack = 1'b0; reti = 1'b0;
    step(2);
    reset = 1'b0;
  endtask
  task automatic set_mask(input logic [3:0] m);
    mask_we = 1'b1; mask_wdata = m;
    step(1);
    mask_we = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1; src = 4'b0001;
    step(2);
    nv++; if (inter !== 1'b0) begin ne++; $display("FAIL rst_inter got %b want 0", inter); end
    nv++; if (vec !== 10'h000) begin ne++; $display("FAIL rst_vec got %h want 000", vec); end
    nv++; if (pend !== 4'b0000) begin ne++; $display("FAIL rst_pend got %b want 0000", pend); end
    nv++; if (in_svc !== 4'b0000) begin ne++; $display("FAIL rst_in_svc got %b want 0000", in_svc); end
    nv++; if (busy !== 1'b0) begin ne++; $display("FAIL rst_busy got %b want 0", busy); end
    reset = 1'b0;
    step(1);
    nv++; if (pend !== 4'b0001) begin ne++; $display("FAIL rst_held_edge pend got %b want 0001", pend); end
    for (int i = 0; i < 20; i++) begin
      step(1);
      nv++; if (inter !== 1'b0) begin ne++; $display("FAIL masked_quiet cyc%0d inter got %b want 0", i, inter); end
    end
    nv++; if (pend !== 4'b0001) begin ne++; $display("FAIL masked_pend_hold got %b want 0001", pend); end
  endtask
  task automatic test_basic();
    do_reset();
    set_mask(4'b1111);
    src = 4'b0100;
    step(1);
    src = '0;
    nv++; if (pend !== 4'b0100) begin ne++; $display("FAIL basic_pend got %b want 0100", pend); end
    nv++; if (inter !== 1'b0) begin ne++; $display("FAIL basic_lat_inter got %b want 0", inter); end
    step(1);
    nv++; if (inter !== 1'b1) begin ne++; $display("FAIL basic_inter got %b want 1", inter); end
    nv++; if (vec !== 10'h3C8) begin ne++; $display("FAIL basic_vec got %h want 3c8", vec); end
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    nv++; if (inter !== 1'b0) begin ne++; $display("FAIL basic_ack_inter got %b want 0", inter); end
    nv++; if (pend !== 4'b0000) begin ne++; $display("FAIL basic_ack_pend got %b want 0000", pend); end
    nv++; if (in_svc !== 4'b0100) begin ne++; $display("FAIL basic_in_svc got %b want 0100", in_svc); end
    nv++; if (vec !== 10'h3C8) begin ne++; $display("FAIL basic_vec_hold got %h want 3c8", vec); end
    reti = 1'b1;
    step(1);
    reti = 1'b0;
    nv++; if (busy !== 1'b0) begin ne++; $display("FAIL basic_reti_busy got %b want 0", busy); end
    nv++; if (in_svc !== 4'b0000) begin ne++; $display("FAIL basic_reti_in_svc got %b want 0000", in_svc); end
  endtask
  task automatic test_priority();
    do_reset();
    set_mask(4'b1111);
    src = 4'b1010;
    step(1);
    src = '0;
    step(1);
    nv++; if (vec !== 10'h3C4) begin ne++; $display("FAIL prio_vec1 got %h want 3c4", vec); end
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    nv++; if (pend !== 4'b1000) begin ne++; $display("FAIL prio_pend got %b want 1000", pend); end
    reti = 1'b1;
    step(1);
    reti = 1'b0;
    nv++; if (inter !== 1'b0) begin ne++; $display("FAIL prio_gap_inter got %b want 0", inter); end
    step(1);
    nv++; if (inter !== 1'b1) begin ne++; $display("FAIL prio_inter2 got %b want 1", inter); end
    nv++; if (vec !== 10'h3CC) begin ne++; $display("FAIL prio_vec2 got %h want 3cc", vec); end
  endtask
  task automatic test_freeze();
    do_reset();
    set_mask(4'b1111);
    src = 4'b0100;
    step(1);
    src = '0;
    step(1);
    src = 4'b0001; mask_we = 1'b1; mask_wdata = 4'b0000;
    step(1);
    src = '0; mask_we = 1'b0;
    nv++; if (vec !== 10'h3C8) begin ne++; $display("FAIL freeze_vec got %h want 3c8", vec); end
    nv++; if (pend !== 4'b0101) begin ne++; $display("FAIL freeze_pend got %b want 0101", pend); end
    step(2);
    nv++; if (vec !== 10'h3C8) begin ne++; $display("FAIL freeze_vec2 got %h want 3c8", vec); end
    nv++; if (inter !== 1'b1) begin ne++; $display("FAIL freeze_inter got %b want 1", inter); end
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    nv++; if (pend !== 4'b0001) begin ne++; $display("FAIL freeze_ack_pend got %b want 0001", pend); end
    reti = 1'b1;
    step(1);
    reti = 1'b0;
    step(3);
    nv++; if (inter !== 1'b0) begin ne++; $display("FAIL freeze_masked_inter got %b want 0", inter); end
    nv++; if (busy !== 1'b0) begin ne++; $display("FAIL freeze_masked_busy got %b want 0", busy); end
    nv++; if (pend !== 4'b0001) begin ne++; $display("FAIL freeze_masked_pend got %b want 0001", pend); end
    set_mask(4'b1111);
    step(1);
    nv++; if (inter !== 1'b1) begin ne++; $display("FAIL unmask_inter got %b want 1", inter); end
    nv++; if (vec !== 10'h3C0) begin ne++; $display("FAIL unmask_vec got %h want 3c0", vec); end
  endtask
  task automatic test_pulses();
    do_reset();
    set_mask(4'b1111);
    src = 4'b0010;
    step(1);
    src = '0;
    step(1);
    reti = 1'b1;
    step(1);
    reti = 1'b0;
    nv++; if (inter !== 1'b1) begin ne++; $display("FAIL stray_reti_inter got %b want 1", inter); end
    nv++; if (in_svc !== 4'b0000) begin ne++; $display("FAIL stray_reti_in_svc got %b want 0000", in_svc); end
    nv++; if (vec !== 10'h3C4) begin ne++; $display("FAIL stray_reti_vec got %h want 3c4", vec); end
    src = 4'b0010; ack = 1'b1;
    step(1);
    src = '0; ack = 1'b0;
    nv++; if (pend !== 4'b0010) begin ne++; $display("FAIL set_beats_clr pend got %b want 0010", pend); end
    nv++; if (in_svc !== 4'b0010) begin ne++; $display("FAIL set_beats_clr in_svc got %b want 0010", in_svc); end
    reti = 1'b1;
    step(1);
    reti = 1'b0;
    step(1);
    nv++; if (inter !== 1'b1) begin ne++; $display("FAIL reeval_inter got %b want 1", inter); end
    ack = 1'b1; reti = 1'b1;
    step(1);
    ack = 1'b0; reti = 1'b0;
    nv++; if (busy !== 1'b1) begin ne++; $display("FAIL ack_reti_busy got %b want 1", busy); end
    nv++; if (in_svc !== 4'b0010) begin ne++; $display("FAIL ack_reti_in_svc got %b want 0010", in_svc); end
    reti = 1'b1;
    step(1);
    reti = 1'b0;
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    nv++; if (busy !== 1'b0) begin ne++; $display("FAIL stray_ack_busy got %b want 0", busy); end
    nv++; if (inter !== 1'b0) begin ne++; $display("FAIL stray_ack_inter got %b want 0", inter); end
    nv++; if (pend !== 4'b0000) begin ne++; $display("FAIL stray_ack_pend got %b want 0000", pend); end
  endtask
  task automatic test_nest();
    do_reset();
    set_mask(4'b1111);
    src = 4'b1000;
    step(1);
    src = '0;
    step(1);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    nv++; if (in_svc !== 4'b1000) begin ne++; $display("FAIL nest_svc3 got %b want 1000", in_svc); end
    src = 4'b0001;
    step(1);
    src = '0;
    step(1);
`ifdef IRQ_NEST_EN
    nv++; if (inter !== 1'b1) begin ne++; $display("FAIL nest_preempt_inter got %b want 1", inter); end
    nv++; if (vec !== 10'h3C0) begin ne++; $display("FAIL nest_preempt_vec got %h want 3c0", vec); end
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    nv++; if (in_svc !== 4'b1001) begin ne++; $display("FAIL nest_ack_in_svc got %b want 1001", in_svc); end
    reti = 1'b1;
    step(1);
    reti = 1'b0;
    nv++; if (in_svc !== 4'b1000) begin ne++; $display("FAIL nest_pop_in_svc got %b want 1000", in_svc); end
    nv++; if (busy !== 1'b1) begin ne++; $display("FAIL nest_pop_busy got %b want 1", busy); end
    reti = 1'b1;
    step(1);
    reti = 1'b0;
    nv++; if (busy !== 1'b0) begin ne++; $display("FAIL nest_idle_busy got %b want 0", busy); end
    nv++; if (in_svc !== 4'b0000) begin ne++; $display("FAIL nest_idle_in_svc got %b want 0000", in_svc); end
`else
    step(2);
    nv++; if (inter !== 1'b0) begin ne++; $display("FAIL nonest_inter got %b want 0", inter); end
    nv++; if (in_svc !== 4'b1000) begin ne++; $display("FAIL nonest_in_svc got %b want 1000", in_svc); end
    reti = 1'b1;
    step(1);
    reti = 1'b0;
    nv++; if (busy !== 1'b0) begin ne++; $display("FAIL nonest_reti_busy got %b want 0", busy); end
    step(1);
    nv++; if (inter !== 1'b1) begin ne++; $display("FAIL nonest_late_inter got %b want 1", inter); end
    nv++; if (vec !== 10'h3C0) begin ne++; $display("FAIL nonest_late_vec got %h want 3c0", vec); end
`endif
  endtask
  task automatic test_mid_reset();
    do_reset();
    set_mask(4'b1111);
    src = 4'b0110;
    step(1);
    src = '0;
    step(1);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    nv++; if (busy !== 1'b0) begin ne++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    nv++; if (in_svc !== 4'b0000) begin ne++; $display("FAIL mid_rst_in_svc got %b want 0000", in_svc); end
    nv++; if (pend !== 4'b0000) begin ne++; $display("FAIL mid_rst_pend got %b want 0000", pend); end
    nv++; if (vec !== 10'h000) begin ne++; $display("FAIL mid_rst_vec got %h want 000", vec); end
    src = 4'b0100;
    step(1);
    src = '0;
    step(3);
    nv++; if (inter !== 1'b0) begin ne++; $display("FAIL mid_rst_mask_cleared inter got %b want 0", inter); end
    nv++; if (pend !== 4'b0100) begin ne++; $display("FAIL mid_rst_new_pend got %b want 0100", pend); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_freeze();
    test_pulses();
    test_nest();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nv, ne);
    $finish;
  end
endmodule
